// File: rtl/monitor_loader.sv
`default_nettype none
// ============================================================================
// monitor_loader - parses framed serial load records from the UART and writes
// them into the 8 KB monitor RAM window, holding the CPU off the bus per frame.
// Optional feature macro: LOADER_TIMEOUT_EN (inter-byte timeout abort).
// Revision: 1.0 - initial release
// ============================================================================
module monitor_loader #(
    parameter int                ADDR_WIDTH     = 13,
    parameter int                DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'h55,
    parameter int                TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code
);

    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_AHI  = 3'd1;
    localparam logic [2:0] C_ALO  = 3'd2;
    localparam logic [2:0] C_LEN  = 3'd3;
    localparam logic [2:0] C_DATA = 3'd4;
    localparam logic [2:0] C_CSUM = 3'd5;
    localparam logic [2:0] C_END  = 3'd6;

    // ADDR_HI bits above the window offset must all be ones (0xE000-0xFFFF)
    localparam logic [7:0] C_HI_MASK = 8'hFF << (ADDR_WIDTH - 8);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  range_q, range_d;
    logic                  hold_q, hold_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_sum_next;

    assign rx_ready   = !rst && (state_q != C_END);
    assign w_accept   = rx_valid && rx_ready;
    assign w_sum_next = sum_q + rx_data;

`ifdef LOADER_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [C_TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        range_d = range_q;
        hold_d  = hold_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        we_d    = 1'b0;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        case (state_q)
            C_IDLE: if (w_accept && rx_data == SYNC_BYTE) begin
                state_d = C_AHI;
                hold_d  = 1'b1;
                range_d = 1'b0;
            end
            C_AHI: if (w_accept) begin
                range_d                  = (rx_data & C_HI_MASK) != C_HI_MASK;
                addr_d[ADDR_WIDTH-1:8]   = rx_data[ADDR_WIDTH-9:0];
                sum_d                    = rx_data;
                state_d                  = C_ALO;
            end
            C_ALO: if (w_accept) begin
                addr_d[7:0] = rx_data;
                sum_d       = w_sum_next;
                state_d     = C_LEN;
            end
            C_LEN: if (w_accept) begin
                cnt_d   = (rx_data == '0) ? 9'd256 : {1'b0, rx_data};
                sum_d   = w_sum_next;
                state_d = C_DATA;
            end
            C_DATA: if (w_accept) begin
                we_d    = !range_q;
                maddr_d = addr_q;
                wdata_d = rx_data;
                addr_d  = addr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q - 9'd1;
                sum_d   = w_sum_next;
                if (cnt_q == 9'd1) state_d = C_CSUM;
            end
            C_CSUM: if (w_accept) begin
                state_d = C_END;
                hold_d  = 1'b0;
                // Range error outranks a bad checksum
                if (range_q) begin
                    err_d  = 1'b1;
                    code_d = 2'b10;
                end else if (w_sum_next != '0) begin
                    err_d  = 1'b1;
                    code_d = 2'b01;
                end else begin
                    ok_d   = 1'b1;
                    code_d = 2'b00;
                end
            end
            C_END:   state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
`ifdef LOADER_TIMEOUT_EN
        tmo_d = '0;
        if (state_q != C_IDLE && state_q != C_END && !w_accept) begin
            if (tmo_q == C_TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = C_IDLE;
                hold_d  = 1'b0;
                err_d   = 1'b1;
                code_d  = 2'b11;
            end else begin
                tmo_d = tmo_q + C_TMO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            range_q <= 1'b0;
            hold_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            range_q <= range_d;
            hold_q  <= hold_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`endif

    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;

endmodule
`default_nettype wire

// File: tb/tb_monitor_loader.sv
`default_nettype none
// Scoreboard bench for monitor_loader: directed frames queue expected writes
// and frame results; a negedge monitor pops and compares them.
module tb_monitor_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_we, cpu_hold, frame_ok, frame_err;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed { logic [12:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic ok; logic [1:0] code; logic rdy; } res_t;
    wr_t  exp_wr[$];
    res_t exp_res[$];
    logic [7:0] payload [256];

    monitor_loader #(
        .ADDR_WIDTH(13), .DATA_WIDTH(8), .SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .frame_ok(frame_ok),
        .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge after the transfer
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!rx_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL rx_ready_stuck: got 0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] ahi, input logic [7:0] alo,
                              input logic [7:0] len, input logic [7:0] csum);
        int          n;
        logic        rng;
        logic [12:0] off;
        logic [7:0]  s;
        res_t        r;
        n   = (len == 8'd0) ? 256 : int'(len);
        rng = (ahi[7:5] != 3'b111);
        off = {ahi[4:0], alo};
        s   = ahi + alo + len + csum;
        send_byte(8'h55);
        send_byte(ahi);
        send_byte(alo);
        send_byte(len);
        for (int i = 0; i < n; i++) begin
            if (!rng) exp_wr.push_back({off, payload[i]});
            off = off + 13'd1;
            s   = s + payload[i];
            send_byte(payload[i]);
        end
        r.ok   = !rng && (s == 8'd0);
        r.code = rng ? 2'b10 : ((s != 8'd0) ? 2'b01 : 2'b00);
        r.rdy  = 1'b0;
        exp_res.push_back(r);
        send_byte(csum);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_wr.size() != 0 || exp_res.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_wr_left", exp_wr.size(), 0);
        check("drain_res_left", exp_res.size(), 0);
        exp_wr.delete();
        exp_res.delete();
    endtask

    // Monitor: compare every DUT write and frame pulse against the scoreboard
    initial begin
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                             mem_addr, mem_wdata);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(w.addr));
                    check("wr_data", 32'(mem_wdata), 32'(w.data));
                    check("hold_during_write", 32'(cpu_hold), 1);
                end
            end
            if (frame_ok || frame_err) begin
                if (exp_res.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_pulse: got ok=%0d err=%0d expected none",
                             frame_ok, frame_err);
                end else begin
                    r = exp_res.pop_front();
                    check("frame_ok", 32'(frame_ok), 32'(r.ok));
                    check("frame_err", 32'(frame_err), 32'(!r.ok));
                    check("err_code", 32'(err_code), 32'(r.code));
                    check("hold_at_pulse", 32'(cpu_hold), 0);
                    check("ready_at_pulse", 32'(rx_ready), 32'(r.rdy));
                end
            end
        end
    end

    initial begin
        logic [7:0] s;
        res_t       r;
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_cpu_hold", 32'(cpu_hold), 0);
        check("rst_pulses", 32'({frame_ok, frame_err}), 0);
        check("rst_err_code", 32'(err_code), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(rx_ready), 1);

        // Good frame
        payload[0] = 8'hA9; payload[1] = 8'h01; payload[2] = 8'h60;
        send_byte(8'h55);
        check("hold_after_sync", 32'(cpu_hold), 1);
        idle(1);
        rx_valid = 1'b0;
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h03);
        exp_wr.push_back({13'h0000, 8'hA9});
        exp_wr.push_back({13'h0001, 8'h01});
        exp_wr.push_back({13'h0002, 8'h60});
        send_byte(8'hA9); send_byte(8'h01); send_byte(8'h60);
        exp_res.push_back({1'b1, 2'b00, 1'b0});
        send_byte(8'h13);
        idle(2);
        drain(20);

        // Bad checksum, then range error, then back-to-back wrap frame
        send_frame(8'hE0, 8'h00, 8'h03, 8'h14);
        payload[0] = 8'hFF;
        send_frame(8'h20, 8'h00, 8'h01, 8'hE0);
        idle(5);
        drain(20);
        check("err_code_holds", 32'(err_code), 32'(2'b10));

        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
        send_frame(8'hFF, 8'hFE, 8'h04, 8'h55);
        idle(2);
        drain(20);

        // Noise then a 256-byte frame
        send_byte(8'h00); send_byte(8'hAA); send_byte(8'h12);
        idle(3);
        check("noise_no_hold", 32'(cpu_hold), 0);
        s = 8'hE0;
        for (int i = 0; i < 256; i++) begin
            payload[i] = 8'(i) ^ 8'h5A;
            s = s + payload[i];
        end
        send_frame(8'hE0, 8'h00, 8'h00, 8'(-s));
        idle(2);
        drain(20);
        check("err_code_ok", 32'(err_code), 0);

        // Stalled frame
        send_byte(8'h55); send_byte(8'hE0); send_byte(8'h00);
`ifdef LOADER_TIMEOUT_EN
        r.ok = 1'b0; r.code = 2'b11; r.rdy = 1'b1;
        exp_res.push_back(r);
        idle(1);
        drain(150);
        check("timeout_hold", 32'(cpu_hold), 0);
        check("timeout_code", 32'(err_code), 32'(2'b11));
        send_byte(8'h55); send_byte(8'hE0); send_byte(8'h00);
`else
        idle(150);
        check("stall_hold", 32'(cpu_hold), 1);
        check("stall_code", 32'(err_code), 0);
`endif
        // Reset mid-frame: no pulse, hold drops
        rx_valid = 1'b0;
        check("hold_before_rst", 32'(cpu_hold), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(rx_ready), 0);
        check("midrst_hold", 32'(cpu_hold), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_code", 32'(err_code), 0);

        // Recovery frame
        payload[0] = 8'hA9; payload[1] = 8'h01; payload[2] = 8'h60;
        send_frame(8'hE0, 8'h00, 8'h03, 8'h13);
        idle(3);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/monitor_loader.md
# monitor_loader

Serial-download writer for the 8 KB monitor memory window (0xE000-0xFFFF). It consumes a byte stream from the UART receiver, parses framed load records, and drives a byte-wide write port into the monitor RAM that replaces the fixed monitor ROM contents. It holds the CPU off the bus while a frame is in flight and reports per-frame success or error to the status logic.

## Interface
- ADDR_WIDTH, 13, memory window address width (8 KB)
- DATA_WIDTH, 8, byte width
- SYNC_BYTE, 8'h55, frame start marker
- TIMEOUT_CYCLES, 2_500_000, max clk cycles between accepted bytes inside a frame (100 ms at 25 MHz)

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle
- rx_ready  out  1  loader accepts byte; transfer when rx_valid && rx_ready
- mem_we  out  1  write strobe to monitor RAM, one cycle per byte
- mem_addr  out  ADDR_WIDTH  write address (window offset)
- mem_wdata  out  DATA_WIDTH  write data
- cpu_hold  out  1  high while a frame is being received
- frame_ok  out  1  one-cycle pulse: frame finished, checksum good
- frame_err  out  1  one-cycle pulse: frame aborted or bad
- err_code  out  2  last error: 00 none, 01 checksum, 10 range, 11 timeout

## Operation
- Frame: SYNC_BYTE, ADDR_HI, ADDR_LO, LEN, LEN data bytes, CSUM. LEN=0 means 256 bytes.
- Checksum rule: (ADDR_HI + ADDR_LO + LEN + all data + CSUM) mod 256 == 0.
- States: IDLE -> AHI -> ALO -> LEN -> DATA -> CSUM -> IDLE.
- IDLE: bytes other than SYNC_BYTE consumed and ignored. SYNC_BYTE -> AHI, cpu_hold rises.
- AHI: ADDR_HI[7:5] != 3'b111 marks frame out-of-range. Frame continues to be parsed, but no writes occur. It ends with frame_err, err_code=10, regardless of checksum.
- LEN: load 9-bit remaining count (0 -> 256). Go to DATA.
- DATA: each accepted byte is written at the current offset (unless out-of-range). Offset then increments modulo 2^ADDR_WIDTH, so 0xFFFF wraps to 0xE000. Remaining count decrements; at zero go to CSUM.
- CSUM: on accept, evaluate the sum. Zero -> frame_ok, err_code=00. Nonzero -> frame_err, err_code=01. Range error takes priority over checksum error.
- Data writes are not rolled back on checksum error. The host resends the frame.
- rx_ready is high in all states except the single end-of-frame cycle and while rst is high.
- Reset mid-frame: returns to IDLE, drops cpu_hold, discards the partial frame, issues no pulse.

## Timing
- Reset values: rx_ready=0 during rst, then 1; mem_we=0; mem_addr=0; mem_wdata=0; cpu_hold=0; frame_ok=0; frame_err=0; err_code=00.
- mem_we, mem_addr and mem_wdata are registered and valid the cycle after the data byte is accepted. Throughput is one write per cycle with back-to-back rx_valid.
- frame_ok/frame_err pulse the cycle after the CSUM byte is accepted. rx_ready=0 in that cycle.
- cpu_hold rises the cycle after SYNC_BYTE is accepted. It falls together with the end-of-frame pulse, so it is low the following cycle.
- err_code updates in the same cycle as the pulse. It holds until the next pulse or reset.
- Timeout counter resets on every accepted byte and counts only outside IDLE.

## Configuration
- LOADER_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES with no accepted byte, the loader returns to IDLE, pulses frame_err with err_code=11 and drops cpu_hold in the same cycle.
- LOADER_TIMEOUT_EN undefined: no timeout counter is built. A stalled frame holds cpu_hold indefinitely, and err_code=11 is never produced.

## Test plan
- Good frame 55 E0 00 03 A9 01 60, CSUM = (-(E0+00+03+A9+01+60)) mod 256 = 0x13 -> writes at offsets 0x0000/1/2 of A9/01/60 on consecutive cycles; frame_ok pulse; err_code=00; cpu_hold spans the frame.
- Same frame with CSUM=0x14 -> same three writes, then frame_err with err_code=01.
- 55 20 00 01 FF then correct CSUM -> no mem_we; frame_err with err_code=10.
- Wrap: 55 FF FE 04 11 22 33 44 + correct CSUM -> writes to offsets 1FFE, 1FFF, 0000, 0001; frame_ok.
- Noise bytes 00 AA 12 in IDLE, then a good LEN=0 frame of 256 bytes -> noise ignored; 256 writes at offsets 0000-00FF; frame_ok.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 55 E0 00, then idle 100 cycles -> frame_err, err_code=11, cpu_hold low. Assert rst mid-frame -> IDLE with no pulse.
